// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage.
// Holds the MIPS-subset opcode/funct encodings, the ALU operation codes
// driven towards execute, the decoded control bundle produced by
// decode_comb, and the RUN/HALT state enumeration used by decode_stage.
package decode_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_HALT = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;
    localparam logic [2:0] ALU_CMP  = 3'b110;

    // Decoded control bundle. wr_rd selects rd (1) or rt (0) as the
    // destination; is_halt marks the halt instruction for the stage FSM.
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src2;
        logic [2:0] alu_op;
        logic       branch_eq;
        logic       branch_ne;
        logic       jump;
        logic       wr_rd;
        logic       is_halt;
    } ctrl_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

endpackage

// File: rtl/decode_comb.sv
// Pure combinational instruction decoder.
// Ports:
//   opcode_i   [5:0]  instr[31:26]
//   funct_i    [5:0]  instr[5:0]
//   ctrl_o     ctrl_t decoded control bundle (all zero for illegal encodings)
//   illegal_o         opcode or funct not recognised
//   reads_rt_o        instruction uses rt as a source operand
module decode_comb
    import decode_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output ctrl_t      ctrl_o,
    output logic       illegal_o,
    output logic       reads_rt_o
);

    always_comb begin
        ctrl_o     = '0;
        illegal_o  = 1'b0;
        reads_rt_o = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                reads_rt_o       = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.wr_rd     = 1'b1;
                case (funct_i)
                    FN_ADD:  ctrl_o.alu_op = ALU_ADD;
                    FN_SUB:  ctrl_o.alu_op = ALU_SUB;
                    FN_AND:  ctrl_o.alu_op = ALU_AND;
                    FN_OR:   ctrl_o.alu_op = ALU_OR;
                    FN_SLT:  ctrl_o.alu_op = ALU_SLT;
                    default: begin
                        // Unknown funct becomes a bubble bundle
                        ctrl_o    = '0;
                        illegal_o = 1'b1;
                    end
                endcase
            end
            OP_ADDI: begin
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.alu_src2  = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            OP_LW: begin
                ctrl_o.alu_op     = ALU_ADD;
                ctrl_o.alu_src2   = 1'b1;
                ctrl_o.mem_read   = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
            end
            OP_SW: begin
                reads_rt_o       = 1'b1;
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.alu_src2  = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            OP_BEQ: begin
                reads_rt_o       = 1'b1;
                ctrl_o.alu_op    = ALU_CMP;
                ctrl_o.branch_eq = 1'b1;
            end
            OP_BNE: begin
                reads_rt_o       = 1'b1;
                ctrl_o.alu_op    = ALU_CMP;
                ctrl_o.branch_ne = 1'b1;
            end
            OP_J: begin
                ctrl_o.jump = 1'b1;
            end
            OP_HALT: begin
                ctrl_o.alu_op  = ALU_HALT;
                ctrl_o.is_halt = 1'b1;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Registered instruction-decode pipeline stage between fetch and execute.
// Accepts one instruction per cycle (if_valid/id_ready), presents the
// decoded bundle one cycle later (ex_valid/ex_ready), inserts a one-cycle
// bubble on a load-use hazard, supports flush, and latches a HALT state
// that only reset can leave.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_valid/if_instr/if_pc  fetch side instruction and its PC
//   id_ready                 stage accepts the instruction this cycle
//   flush                    kill the bundle in decode and the one arriving
//   ex_ready                 execute consumes the bundle
//   ex_*                     registered decoded bundle towards execute
//   illegal                  one-cycle pulse for an accepted unknown encoding
//   halted                   stage has entered HALT
module decode_stage
    import decode_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int IMM_W     = 32,
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    input  logic [31:0]       if_pc,
    output logic              id_ready,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_alu_src2,
    output logic [2:0]        ex_alu_op,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_wr_addr,
    output logic [IMM_W-1:0]  ex_imm,
    output logic              ex_branch_eq,
    output logic              ex_branch_ne,
    output logic              ex_jump,
    output logic [25:0]       ex_jump_target,
    output logic              illegal,
    output logic              halted
);

    ctrl_t dec_ctrl;
    logic  dec_illegal;
    logic  dec_reads_rt;

    decode_comb u_decode_comb (
        .opcode_i   (if_instr[31:26]),
        .funct_i    (if_instr[5:0]),
        .ctrl_o     (dec_ctrl),
        .illegal_o  (dec_illegal),
        .reads_rt_o (dec_reads_rt)
    );

    // Register fields truncated to the configured address width
    logic [4:0]        rs_field, rt_field, rd_field;
    logic [REG_AW-1:0] rs_a, rt_a, rd_a;

    assign rs_field = if_instr[25:21];
    assign rt_field = if_instr[20:16];
    assign rd_field = if_instr[15:11];
    assign rs_a     = rs_field[REG_AW-1:0];
    assign rt_a     = rt_field[REG_AW-1:0];
    assign rd_a     = rd_field[REG_AW-1:0];

    // Next-state bundle values
    logic [REG_AW-1:0] wr_addr_d;
    logic              reg_write_d;
    logic [IMM_W-1:0]  imm_d;

    always_comb begin
        wr_addr_d = '0;
        if (dec_ctrl.reg_write) begin
            wr_addr_d = dec_ctrl.wr_rd ? rd_a : rt_a;
        end
    end

    // Writes to r0 are architecturally discarded
    assign reg_write_d = dec_ctrl.reg_write & (wr_addr_d != '0);
    assign imm_d       = IMM_W'($signed(if_instr[15:0]));

    // Pipeline register state
    state_e            state_q;
    logic              halted_q;
    logic              ex_valid_q;
    logic [31:0]       ex_pc_q;
    logic              reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q;
    logic              alu_src2_q;
    logic [2:0]        alu_op_q;
    logic [REG_AW-1:0] rs_q, rt_q, wr_addr_q;
    logic [IMM_W-1:0]  imm_q;
    logic              branch_eq_q, branch_ne_q, jump_q;
    logic [25:0]       jump_target_q;
    logic              illegal_q;

    // Load-use interlock: the load in execute targets a register the
    // instruction being presented reads.
    logic hazard;

    generate
        if (HAZARD_EN) begin : g_hazard
            assign hazard = ex_valid_q & mem_read_q & (wr_addr_q != '0) &
                            ((wr_addr_q == rs_a) |
                             ((wr_addr_q == rt_a) & dec_reads_rt));
        end else begin : g_no_hazard
            assign hazard = 1'b0;
        end
    endgenerate

    logic accept;

    assign id_ready = ~rst & (state_q == ST_RUN) & ~hazard & (~ex_valid_q | ex_ready);
    assign accept   = if_valid & id_ready;

    // RUN/HALT state machine
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (accept && !flush && dec_ctrl.is_halt) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end
                end
                ST_HALT: begin
                    state_q  <= ST_HALT;
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q  <= ST_RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    // Output bundle register
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_to_reg_q  <= 1'b0;
            alu_src2_q    <= 1'b0;
            alu_op_q      <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            wr_addr_q     <= '0;
            imm_q         <= '0;
            branch_eq_q   <= 1'b0;
            branch_ne_q   <= 1'b0;
            jump_q        <= 1'b0;
            jump_target_q <= '0;
            illegal_q     <= 1'b0;
        end else if (flush) begin
            // Drops both the bundle in decode and anything accepted now
            ex_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else if (accept) begin
            ex_valid_q    <= 1'b1;
            ex_pc_q       <= if_pc;
            reg_write_q   <= reg_write_d;
            mem_read_q    <= dec_ctrl.mem_read;
            mem_write_q   <= dec_ctrl.mem_write;
            mem_to_reg_q  <= dec_ctrl.mem_to_reg;
            alu_src2_q    <= dec_ctrl.alu_src2;
            alu_op_q      <= dec_ctrl.alu_op;
            rs_q          <= rs_a;
            rt_q          <= rt_a;
            wr_addr_q     <= wr_addr_d;
            imm_q         <= imm_d;
            branch_eq_q   <= dec_ctrl.branch_eq;
            branch_ne_q   <= dec_ctrl.branch_ne;
            jump_q        <= dec_ctrl.jump;
            jump_target_q <= if_instr[25:0];
            illegal_q     <= dec_illegal;
        end else begin
            // Consumed with nothing new (stall bubble or idle); otherwise hold
            if (ex_ready) begin
                ex_valid_q <= 1'b0;
            end
            illegal_q <= 1'b0;
        end
    end

    assign ex_valid       = ex_valid_q;
    assign ex_pc          = ex_pc_q;
    assign ex_reg_write   = reg_write_q;
    assign ex_mem_read    = mem_read_q;
    assign ex_mem_write   = mem_write_q;
    assign ex_mem_to_reg  = mem_to_reg_q;
    assign ex_alu_src2    = alu_src2_q;
    assign ex_alu_op      = alu_op_q;
    assign ex_rs          = rs_q;
    assign ex_rt          = rt_q;
    assign ex_wr_addr     = wr_addr_q;
    assign ex_imm         = imm_q;
    assign ex_branch_eq   = branch_eq_q;
    assign ex_branch_ne   = branch_ne_q;
    assign ex_jump        = jump_q;
    assign ex_jump_target = jump_target_q;
    assign illegal        = illegal_q;
    assign halted         = halted_q;

endmodule
